// File: rtl/board_debug_display.sv
// rtl/board_debug_display.sv - selectable counter/write-capture debug view for board HEX and LEDs
//
// Purpose:
//   Free-running counter plus capture of processor memory writes (address,
//   data, saturating count). A debounced key steps the display through four
//   views: counter nibble, write data, write address, write count.
//
// Ports:
//   iCLK, iRST_n        clock, asynchronous active-low reset
//   iCNT_CLR            synchronous counter clear (wins over increment)
//   iKEY_n              raw active-low mode key, asynchronous to iCLK
//   iWR_EN/ADDR/DATA    processor memory write strobe, address, data
//   iHOLD               freeze oHEX while high (only with BDD_HOLD_EN)
//   oHEX                active-low segments, digit i at [7i+6:7i], order g..a
//   oLEDR               counter[CNT_TAP+1:CNT_TAP-1] replicated 6 times
//   oLEDG               [3:0] one-hot mode, [7:4] counter nibble, [8] write activity
//   oMODE               current display mode
//
// Optional feature: define BDD_HOLD_EN to add the iHOLD display freeze input.

module board_debug_display #(
  parameter int NUM_DIGITS      = 8,
  parameter int CNT_WIDTH       = 32,
  parameter int CNT_TAP         = 24,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACT_CYCLES      = 2500000
) (
  input  logic                    iCLK,
  input  logic                    iRST_n,
  input  logic                    iCNT_CLR,
  input  logic                    iKEY_n,
  input  logic                    iWR_EN,
  input  logic [31:0]             iWR_ADDR,
  input  logic [31:0]             iWR_DATA,
`ifdef BDD_HOLD_EN
  input  logic                    iHOLD,
`endif
  output logic [7*NUM_DIGITS-1:0] oHEX,
  output logic [17:0]             oLEDR,
  output logic [8:0]              oLEDG,
  output logic [1:0]              oMODE
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ACT_W = (ACT_CYCLES > 1) ? $clog2(ACT_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ACT_W-1:0] ACT_LOAD = ACT_W'(ACT_CYCLES - 1);

  typedef enum logic [1:0] {
    COUNTER = 2'd0,
    WDATA   = 2'd1,
    WADDR   = 2'd2,
    WCOUNT  = 2'd3
  } mode_t;

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [31:0]          wr_addr_q;
  logic [31:0]          wr_data_q;
  logic [31:0]          wr_cnt_q;
  logic [ACT_W-1:0]     act_q;
  logic                 key_meta_q;
  logic                 key_sync_q;
  logic                 key_acc_q;
  logic [DB_W-1:0]      db_cnt_q;
  logic                 accept;
  logic                 step;
  logic                 hold;
  mode_t                mode_q;
  mode_t                mode_d;
  logic [3:0]           cnt_nib;
  logic [31:0]          disp_word;
  logic [7*NUM_DIGITS-1:0] hex_d;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

`ifdef BDD_HOLD_EN
  assign hold = iHOLD;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cnt_q <= '0;
    end else if (iCNT_CLR) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  // Write capture; the count sticks at all-ones instead of wrapping, and each
  // write restarts the activity stretch.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_cnt_q  <= '0;
      act_q     <= '0;
    end else begin
      if (iWR_EN) begin
        wr_addr_q <= iWR_ADDR;
        wr_data_q <= iWR_DATA;
        if (wr_cnt_q != 32'hFFFF_FFFF) begin
          wr_cnt_q <= wr_cnt_q + 32'd1;
        end
        act_q <= ACT_LOAD;
      end else if (act_q != '0) begin
        act_q <= act_q - ACT_W'(1);
      end
    end
  end

  // Key path works in "pressed" polarity so the all-zero reset state means
  // released, and no spurious press is seen after reset.
  assign accept = (key_sync_q != key_acc_q) && (db_cnt_q == DB_LAST);
  assign step   = accept && key_sync_q;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      key_meta_q <= 1'b0;
      key_sync_q <= 1'b0;
      key_acc_q  <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      key_meta_q <= ~iKEY_n;
      key_sync_q <= key_meta_q;
      if (key_sync_q == key_acc_q) begin
        db_cnt_q <= '0;
      end else if (accept) begin
        key_acc_q <= key_sync_q;
        db_cnt_q  <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      mode_q <= COUNTER;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (step) begin
      case (mode_q)
        COUNTER: mode_d = WDATA;
        WDATA:   mode_d = WADDR;
        WADDR:   mode_d = WCOUNT;
        default: mode_d = COUNTER;
      endcase
    end
  end

  assign cnt_nib = cnt_q[CNT_TAP+3:CNT_TAP];

  always_comb begin
    disp_word = {8{cnt_nib}};
    case (mode_q)
      WDATA:   disp_word = wr_data_q;
      WADDR:   disp_word = wr_addr_q;
      WCOUNT:  disp_word = wr_cnt_q;
      default: disp_word = {8{cnt_nib}};
    endcase
  end

  always_comb begin
    hex_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_d[7*i +: 7] = seg7(disp_word[4*i +: 4]);
    end
  end

  // Output register stage; hold only gates the HEX word so LEDs stay live.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oHEX  <= '1;
      oLEDR <= '0;
      oLEDG <= '0;
    end else begin
      if (!hold) begin
        oHEX <= hex_d;
      end
      oLEDR <= {6{cnt_q[CNT_TAP+1:CNT_TAP-1]}};
      oLEDG <= {(act_q != '0), cnt_nib, 4'b0001 << mode_q};
    end
  end

  assign oMODE = mode_q;

endmodule

// File: tb/tb_board_debug_display.sv
// tb/tb_board_debug_display.sv - directed self-checking bench for board_debug_display

module tb_board_debug_display;

  localparam int DB  = 4;
  localparam int ACT = 8;
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        CLOCK_50 = 1'b0;
  logic        rst_n    = 1'b0;
  logic        cnt_clr  = 1'b0;
  logic        key_n    = 1'b1;
  logic        wr_en    = 1'b0;
  logic [31:0] wr_addr  = '0;
  logic [31:0] wr_data  = '0;
`ifdef BDD_HOLD_EN
  logic        hold     = 1'b0;
`endif
  logic [55:0] hex;
  logic [17:0] ledr;
  logic [8:0]  ledg;
  logic [1:0]  mode;

  int n_checks = 0;
  int n_pass   = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  board_debug_display #(
    .NUM_DIGITS(8), .CNT_WIDTH(32), .CNT_TAP(24),
    .DEBOUNCE_CYCLES(DB), .ACT_CYCLES(ACT)
  ) dut (
    .iCLK(CLOCK_50), .iRST_n(rst_n), .iCNT_CLR(cnt_clr), .iKEY_n(key_n),
    .iWR_EN(wr_en), .iWR_ADDR(wr_addr), .iWR_DATA(wr_data),
`ifdef BDD_HOLD_EN
    .iHOLD(hold),
`endif
    .oHEX(hex), .oLEDR(ledr), .oLEDG(ledg), .oMODE(mode)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [55:0] exp_hex(input logic [31:0] w);
    logic [55:0] r;
    for (int i = 0; i < 8; i++) r[7*i +: 7] = SEG[w[4*i +: 4]];
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic press();
    key_n = 1'b0;
    tick(10);
    key_n = 1'b1;
    tick(10);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    tick(1);
    wr_en   = 1'b0;
  endtask

  logic [1:0] exp_modes [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] exp_oh    [4] = '{4'h2, 4'h4, 4'h8, 4'h1};

  initial begin
    tick(2);
    check("rst_hex",  hex,  {56{1'b1}});
    check("rst_ledr", ledr, 18'h0);
    check("rst_ledg", ledg, 9'h0);
    check("rst_mode", mode, 2'd0);

    rst_n = 1'b1;
    tick(4);
    check("idle_hex",  hex,  exp_hex(32'h0));
    check("idle_ledg", ledg, 9'h001);
    check("idle_ledr", ledr, 18'h0);
    check("idle_mode", mode, 2'd0);

    // Short bounce is rejected, a held press steps exactly once.
    key_n = 1'b0;
    tick(3);
    key_n = 1'b1;
    tick(10);
    check("bounce_mode", mode, 2'd0);
    key_n = 1'b0;
    tick(5);
    check("press_early", mode, 2'd0);
    tick(1);
    check("press_accept", mode, 2'd1);
    tick(4);
    check("press_once", mode, 2'd1);
    key_n = 1'b1;
    tick(10);
    check("release_nostep", mode, 2'd1);

    press();
    press();
    press();
    check("back_to_0", mode, 2'd0);

    for (int i = 0; i < 4; i++) begin
      press();
      check("seq_mode", mode, exp_modes[i]);
      check("seq_ledg", ledg[3:0], exp_oh[i]);
    end

    // Write capture latency and data/address/count views.
    press();
    check("m1_mode", mode, 2'd1);
    wr(32'h1000_0004, 32'hDEAD_BEEF);
    check("wr_lat1", hex, exp_hex(32'h0));
    tick(1);
    check("wr_data", hex, exp_hex(32'hDEAD_BEEF));
    press();
    check("wr_addr", hex, exp_hex(32'h1000_0004));
    press();
    check("wr_cnt1", hex, exp_hex(32'h1));

    force dut.wr_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.wr_cnt_q;
    wr(32'h0, 32'h1);
    wr(32'h0, 32'h2);
    wr(32'h0, 32'h3);
    tick(1);
    check("cnt_sat", hex, exp_hex(32'hFFFF_FFFF));
    tick(ACT - 2);
    check("act_end_hi", ledg[8], 1'b1);
    tick(1);
    check("act_end_lo", ledg[8], 1'b0);

    // Counter clear has priority; view returns to mode 0.
    press();
    check("m0_mode", mode, 2'd0);
    force dut.cnt_q = 32'h0F00_0000;
    #1;
    release dut.cnt_q;
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    check("clr_pre_ledg", ledg, 9'h0F1);
    check("clr_pre_ledr", ledr, 18'h36DB6);
    check("clr_pre_hex",  hex,  exp_hex(32'hFFFF_FFFF));
    tick(1);
    check("clr_ledg", ledg, 9'h001);
    check("clr_ledr", ledr, 18'h0);
    check("clr_hex",  hex,  exp_hex(32'h0));

    // Reset in the middle of an activity stretch and a debounce.
    press();
    wr(32'h2, 32'h1234_5678);
    key_n = 1'b0;
    tick(4);
    check("mid_act", ledg[8], 1'b1);
    check("mid_mode", mode, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_hex",  hex,  {56{1'b1}});
    check("arst_ledr", ledr, 18'h0);
    check("arst_ledg", ledg, 9'h0);
    check("arst_mode", mode, 2'd0);
    key_n = 1'b1;
    #4;
    rst_n = 1'b1;
    tick(10);
    check("post_rst_mode", mode, 2'd0);
    check("post_rst_ledg", ledg, 9'h001);
    check("post_rst_hex",  hex,  exp_hex(32'h0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
